// File: rtl/pipe_stage_chain_if.sv
// Stage-chain bus: pipeline control (stall/flush), the entry entering stage 0,
// the entry leaving the last stage, and the occupancy count.
interface pipe_stage_chain_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 4
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, data_i,
    input  valid_o, ctrl_o, data_o, count_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, data_i,
    output valid_o, ctrl_o, data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline latch with stall, flush (bubble insertion), control squash
// on invalid entries and a registered occupancy count. PIPE_STAGE_PERF_EN adds stall/kill counters.
module pipe_stage_chain #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  pipe_stage_chain_if.slave   bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         kill_cnt_o
`endif
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Flush beats stall beats shift; data registers are never squashed.
  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned and infers a latch.
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      data_d[k]  = data_q[k];
    end
    count_d = count_q;

    if (bus.flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end
      count_d = '0;
    end else if (!bus.stall_i) begin
      valid_d[0] = bus.valid_i;
      ctrl_d[0]  = bus.valid_i ? bus.ctrl_i : '0;
      data_d[0]  = bus.data_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      count_d = count_q + CNT_W'(bus.valid_i) - CNT_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: data registers are reset too, so every output reads 0 while reset is held.
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: non-blocking updates let each stage sample its predecessor's pre-edge value.
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        data_q[k]  <= data_d[k];
      end
      count_q <= count_d;
    end
  end

  assign bus.valid_o = valid_q[DEPTH-1];
  assign bus.ctrl_o  = ctrl_q[DEPTH-1];
  assign bus.data_o  = data_q[DEPTH-1];
  assign bus.count_o = count_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] kill_cnt_q;

  // count_q equals the number of valid stages, i.e. the entries a flush destroys.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else if (bus.flush_i) begin
      kill_cnt_q  <= kill_cnt_q + 32'(count_q);
    end else if (bus.stall_i) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule
